// File: rtl/seq_det_pkg.sv
// Shared types for the 1011 sequence detector: controller and core state
// encodings plus the pattern being searched for.
package seq_det_pkg;

    localparam logic [3:0] PATTERN = 4'b1011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } ctrl_state_e;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } core_state_e;

endpackage

// File: rtl/seq_det_core.sv
// Overlapping Moore detector for 1011; advances only on step, out is state==S4
// one cycle after the completing step; no backpressure, clr forces S0.
module seq_det_core
    import seq_det_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic step,
    input  logic in,
    output logic out
);

    core_state_e state;
    core_state_e state_nxt;

    always_comb begin
        state_nxt = state;
        if (step) begin
            case (state)
                S0:      state_nxt = in ? S1 : S0;
                S1:      state_nxt = in ? S1 : S2;
                S2:      state_nxt = in ? S3 : S0;
                S3:      state_nxt = in ? S4 : S2;
                S4:      state_nxt = in ? S1 : S2;
                default: state_nxt = S0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state <= S0;
        end else begin
            state <= state_nxt;
        end
    end

    assign out = (state == S4);

endmodule

// File: rtl/seq_det_ctrl.sv
// Word-serial 1011 counter: accept in IDLE, WORD_W shift cycles, FLUSH, DONE; done at accept+WORD_W+2.
// in_ready only in IDLE (words held off otherwise). SEQ_DET_CTRL_CARRY_EN keeps detector state across words.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WORD_W-1:0]         in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      hit,
    output logic [$clog2(WORD_W):0]   hit_count,
    output logic                      busy,
    output logic                      done
);

    localparam int CNT_W = $clog2(WORD_W);
    localparam int HC_W  = $clog2(WORD_W) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    ctrl_state_e        state;
    logic [WORD_W-1:0]  shreg;
    logic [CNT_W-1:0]   bit_cnt;
    logic [HC_W-1:0]    count;
    logic               step;
    logic               step_q;
    logic               accept;
    logic               core_clr;
    logic               core_out;
    logic               hit_raw;

    assign accept  = in_valid && (state == IDLE);
    assign step    = (state == SHIFT);
    assign hit_raw = core_out && step_q;

`ifdef SEQ_DET_CTRL_CARRY_EN
    assign core_clr = 1'b0;
`else
    assign core_clr = accept;
`endif

    seq_det_core u_core (
        .clk  (clk),
        .rst  (rst),
        .clr  (core_clr),
        .step (step),
        .in   (shreg[WORD_W-1]),
        .out  (core_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            count   <= '0;
            step_q  <= 1'b0;
        end else begin
            step_q <= step;
            if (accept) begin
                count <= '0;
            end else if (hit_raw) begin
                count <= count + HC_W'(1);
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg   <= in_data;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg   <= shreg << 1;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == LAST_BIT) begin
                        state <= FLUSH;
                    end
                end
                FLUSH:   state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are forced to their idle values while rst is held, not just after it.
    assign in_ready  = (state == IDLE) || rst;
    assign hit       = hit_raw && !rst;
    assign busy      = ((state == SHIFT) || (state == FLUSH)) && !rst;
    assign done      = (state == DONE) && !rst;
    assign hit_count = rst ? '0 : count;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: directed and random words against a sliding-window pattern model.
module tb_seq_det_ctrl;
    import seq_det_pkg::*;

    localparam int W    = 8;
    localparam int HC_W = $clog2(W) + 1;
`ifdef SEQ_DET_CTRL_CARRY_EN
    localparam bit CARRY = 1'b1;
`else
    localparam bit CARRY = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic [W-1:0]    in_data;
    logic            in_valid;
    logic            in_ready;
    logic            hit;
    logic [HC_W-1:0] hit_count;
    logic            busy;
    logic            done;

    int tests;
    int fails;
    int hist;
    int nhist;
    int last_count;

    seq_det_ctrl #(.WORD_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .hit       (hit),
        .hit_count (hit_count),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            chk("idle_ready", 32'(in_ready), 32'd1);
            chk("idle_hit", 32'(hit), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_hold_count", 32'(hit_count), 32'(last_count));
        end
    endtask

    // Offer one word in the coming IDLE cycle and check every cycle through DONE.
    // abort_at>0 pulses rst in that cycle; exp_final>=0 adds an absolute count check.
    task automatic send_word(input logic [W-1:0] data, input bit hold,
                             input int abort_at, input int exp_final);
        bit exp_hit [0:W+2];
        int cnt;
        @(negedge clk);
        chk("accept_ready", 32'(in_ready), 32'd1);
        chk("accept_busy", 32'(busy), 32'd0);
        in_valid = 1'b1;
        in_data  = data;
        if (!CARRY) nhist = 0;
        for (int i = 0; i <= W + 2; i++) exp_hit[i] = 1'b0;
        for (int i = 0; i < W; i++) begin
            hist  = ((hist << 1) | int'(data[W-1-i])) & 15;
            nhist = nhist + 1;
            if (nhist >= 4 && hist == int'(PATTERN)) exp_hit[i+2] = 1'b1;
        end
        cnt = 0;
        for (int c = 1; c <= W + 2; c++) begin
            @(negedge clk);
            in_valid = hold ? 1'b1 : 1'($urandom_range(0, 1));
            in_data  = W'($urandom);
            chk("hit", 32'(hit), 32'(exp_hit[c]));
            chk("busy", 32'(busy), 32'(c <= W + 1));
            chk("done", 32'(done), 32'(c == W + 2));
            chk("ready_low", 32'(in_ready), 32'd0);
            chk("hit_count", 32'(hit_count), 32'(cnt));
            if (c == abort_at) begin
                rst = 1'b1;
                #1;
                chk("rst_ready", 32'(in_ready), 32'd1);
                chk("rst_hit", 32'(hit), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_count", 32'(hit_count), 32'd0);
                @(negedge clk);
                rst      = 1'b0;
                in_valid = 1'b0;
                nhist    = 0;
                last_count = 0;
                chk("post_rst_ready", 32'(in_ready), 32'd1);
                chk("post_rst_count", 32'(hit_count), 32'd0);
                chk("post_rst_done", 32'(done), 32'd0);
                chk("post_rst_busy", 32'(busy), 32'd0);
                return;
            end
            if (exp_hit[c]) cnt++;
        end
        in_valid = hold;
        if (exp_final >= 0) chk("final_count_directed", 32'(hit_count), 32'(exp_final));
        last_count = cnt;
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        hist       = 0;
        nhist      = 0;
        last_count = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;

        repeat (2) @(negedge clk);
        chk("reset_ready", 32'(in_ready), 32'd1);
        chk("reset_hit", 32'(hit), 32'd0);
        chk("reset_count", 32'(hit_count), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        rst = 1'b0;
        idle(2);

        send_word(8'h0B, 1'b0, 0, 1);
        idle(1);
        send_word(8'hB6, 1'b0, 0, 2);
        idle(2);
        send_word(8'h00, 1'b1, 0, 0);
        send_word(8'h00, 1'b1, 0, 0);
        send_word(8'h05, 1'b0, 0, 0);
        send_word(8'h80, 1'b0, 0, CARRY ? 1 : 0);
        idle(1);
        send_word(8'hB6, 1'b0, 4, -1);
        send_word(8'h0B, 1'b0, 0, 1);
        idle(1);

        for (int k = 0; k < 40; k++) begin
            send_word(W'($urandom), 1'($urandom_range(0, 1)), 0, -1);
            idle($urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 SHALL have parameter WORD_W, default 8, meaning the width of the parallel input word (legal values 4..32).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port in_data, input, WORD_W, the word to scan; it is serialized MSB first.
REQ-005 SHALL have port in_valid, input, 1, meaning in_data is offered.
REQ-006 SHALL have port in_ready, output, 1, meaning the controller accepts a word this cycle.
REQ-007 SHALL have port hit, output, 1, a one-cycle pulse for each detection of pattern 1011.
REQ-008 SHALL have port hit_count, output, $clog2(WORD_W)+1, the number of detections in the current or last word.
REQ-009 SHALL have port busy, output, 1, high in SHIFT and FLUSH.
REQ-010 SHALL have port done, output, 1, a one-cycle pulse when hit_count is final.

Function
REQ-011 SHALL implement a controller FSM with states IDLE, SHIFT, FLUSH and DONE.
REQ-012 SHALL assert in_ready only in IDLE; a word is accepted when in_valid and in_ready are both high, which loads the shift register, clears bit_cnt and hit_count, and moves to SHIFT.
REQ-013 SHIFT SHALL last exactly WORD_W cycles; in each cycle it drives shreg MSB to the core with step=1, then shifts left; after bit WORD_W-1 it moves to FLUSH.
REQ-014 FLUSH SHALL last 1 cycle with step=0 so that the Moore output for the last bit is sampled; it then moves to DONE.
REQ-015 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-016 Core: overlapping Moore detector for 1011 with states S0, S1, S2, S3, S4, which advances only when step=1.
REQ-017 Core transitions, given as in=0/in=1:
- S0 -> S0/S1
- S1 -> S2/S1
- S2 -> S0/S3
- S3 -> S2/S4
- S4 -> S2/S1
REQ-018 Core output SHALL be (state==S4) and registered, appearing the cycle after the step that completes the pattern.
REQ-019 hit SHALL equal core_out AND step_q, where step_q is step delayed by one cycle; hit_count SHALL increment on hit.
REQ-020 Latency: for an accept in cycle T, done SHALL be high in cycle T+WORD_W+2 and in_ready high again in T+WORD_W+3.
REQ-021 hit_count SHALL hold its value from DONE until the next accept.
REQ-022 in_valid and in_data SHALL be ignored outside IDLE.
REQ-023 hit_count width SHALL be sufficient without saturation: at most WORD_W detections per word.

Reset
REQ-024 rst=1 at any clock edge SHALL force the FSM to IDLE, the core to S0, and shreg, bit_cnt, hit_count and step_q to 0.
REQ-025 During and immediately after reset, outputs SHALL be in_ready=1, hit=0, hit_count=0, busy=0, done=0.
REQ-026 Reset mid-word SHALL abandon the word with no done pulse; the next cycle accepts a new word.

Configuration
REQ-027 Macro SEQ_DET_CTRL_CARRY_EN:
- When defined, the core state persists across words, so a pattern spanning a word boundary is detected and counted in the later word.
- When undefined, the core is forced to S0 on every accept.

Structure
REQ-028 Package seq_det_pkg SHALL hold the controller state enum (IDLE, SHIFT, FLUSH, DONE), the core state enum (S0..S4) and the constant PATTERN = 4'b1011.
REQ-029 The detector SHALL be a separate sub-module, seq_det_core, with ports clk, rst, clr, step, in and out; seq_det_ctrl instantiates it once.

Verification
REQ-030 Word 8'h0B: hit pulses once, in the FLUSH cycle; done at T+10; hit_count=1.
REQ-031 Word 8'hB6: hit pulses at T+5 and T+8; hit_count=2.
REQ-032 Word 8'h00, offered back-to-back with in_valid held high: hit_count=0; the second word is accepted at T+11 with no gap or overlap.
REQ-033 Word 8'h05 then 8'h80:
- With SEQ_DET_CTRL_CARRY_EN, the second word gives hit_count=1, with hit at the cycle after its first SHIFT.
- Without it, the second word gives hit_count=0.
REQ-034 Word 8'hB6 with rst pulsed in the 4th SHIFT cycle: no done pulse; the next cycle shows in_ready=1 and hit_count=0; a following 8'h0B gives hit_count=1.
